lcd_time_writer: RTL and testbench

LCD_TIME_WRITER -- requirements
Module: lcd_time_writer

---
 rtl/lcd_time_writer_if.sv | 26 ++
 rtl/lcd_time_writer.sv | 155 +++++++++++++++
 tb/tb_lcd_time_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_time_writer_if.sv
// Byte channel between the time writer and an LCD display interface.
//   chcode    : character or command byte
//   ch_is_cmd : 1 = command byte, 0 = data byte
//   ch_valid  : chcode/ch_is_cmd are valid
//   ch_ready  : consumer accepts the byte in this cycle
// The byte transfers on a cycle where ch_valid and ch_ready are both high.
interface lcd_time_writer_if;
  logic [7:0] chcode;
  logic       ch_is_cmd;
  logic       ch_valid;
  logic       ch_ready;

  modport master (
    output chcode,
    output ch_is_cmd,
    output ch_valid,
    input  ch_ready
  );

  modport slave (
    input  chcode,
    input  ch_is_cmd,
    input  ch_valid,
    output ch_ready
  );
endinterface

// File: rtl/lcd_time_writer.sv
// lcd_time_writer: periodically renders an HH:MM:SS clock onto one LCD line.
// Each frame is one address command followed by eight characters
// "HH:MM:SS", sent over a valid/ready byte channel.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst        : asynchronous, active-low reset
//   time_bcd   : six BCD digits, [23:20] hour tens .. [3:0] second units
//   update_req : single-cycle request for an immediate redraw
//   ch         : byte channel (master side): chcode, ch_is_cmd, ch_valid, ch_ready
//   busy       : a frame is in progress
//   frame_done : one-cycle pulse in the final cycle of a frame
module lcd_time_writer #(
  parameter int unsigned REFRESH_CYCLES = 1000,
  parameter logic [7:0]  LINE_ADDR      = 8'h80
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [23:0]               time_bcd,
  input  logic                      update_req,
  lcd_time_writer_if.master         ch,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_NEXT = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'd8;

  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [23:0]      snap_q, snap_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       chcode_q, chcode_d;
  logic             is_cmd_q, is_cmd_d;
  logic             ch_valid_q, ch_valid_d;
  logic             busy_q, busy_d;
  logic             fd_q, fd_d;
  logic             refresh_tick;

  // ASCII for one BCD nibble; anything that is not a decimal digit shows '?'.
  function automatic logic [7:0] digit_char(input logic [3:0] nib);
    if (nib > 4'd9) return 8'h3F;
    return 8'h30 + {4'h0, nib};
  endfunction

  // Byte at position idx of the frame "<addr>HH:MM:SS".
  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [23:0] t);
    case (idx)
      4'd0:    return LINE_ADDR;
      4'd1:    return digit_char(t[23:20]);
      4'd2:    return digit_char(t[19:16]);
      4'd4:    return digit_char(t[15:12]);
      4'd5:    return digit_char(t[11:8]);
      4'd7:    return digit_char(t[7:4]);
      4'd8:    return digit_char(t[3:0]);
      default: return 8'h3A;
    endcase
  endfunction

  // The counter is reloaded with REFRESH_CYCLES-1 at LOAD, so it "reaches
  // zero" on the cycle it holds 1; acting then keeps automatic LOADs exactly
  // REFRESH_CYCLES apart. The reset value 0 also counts as expired, which
  // starts a frame on the first edge after reset.
  assign refresh_tick = (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    cnt_d   = refresh_tick ? RELOAD : cnt_q - CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (refresh_tick || update_req || pend_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        snap_d  = time_bcd;
        idx_d   = 4'd0;
        cnt_d   = RELOAD;
        // A request arriving in this very cycle still earns a redraw.
        pend_d  = update_req;
        state_d = S_SEND;
      end
      S_SEND: begin
        pend_d = pend_q | update_req | refresh_tick;
        if (ch_valid_q && ch.ch_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        pend_d = pend_q | update_req | refresh_tick;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the byte is loaded as
  // SEND is entered and simply held while the consumer stalls.
  always_comb begin
    chcode_d = chcode_q;
    is_cmd_d = is_cmd_q;
    if (state_d == S_SEND) begin
      chcode_d = frame_byte(idx_d, snap_d);
      is_cmd_d = (idx_d == 4'd0);
    end
    ch_valid_d = (state_d == S_SEND);
    busy_d     = (state_d != S_IDLE);
    fd_d       = (state_d == S_NEXT) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      snap_q     <= 24'h0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      chcode_q   <= 8'h00;
      is_cmd_q   <= 1'b0;
      ch_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      chcode_q   <= chcode_d;
      is_cmd_q   <= is_cmd_d;
      ch_valid_q <= ch_valid_d;
      busy_q     <= busy_d;
      fd_q       <= fd_d;
    end
  end

  assign ch.chcode    = chcode_q;
  assign ch.ch_is_cmd = is_cmd_q;
  assign ch.ch_valid  = ch_valid_q;
  assign busy         = busy_q;
  assign frame_done   = fd_q;

endmodule

// File: tb/tb_lcd_time_writer.sv
// Directed bench for lcd_time_writer (REFRESH_CYCLES = 100).
module tb_lcd_time_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] time_bcd = 24'h0;
  logic        update_req = 1'b0;
  logic        busy;
  logic        frame_done;

  lcd_time_writer_if ch_if ();

  lcd_time_writer #(
    .REFRESH_CYCLES(100),
    .LINE_ADDR     (8'h80)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .time_bcd  (time_bcd),
    .update_req(update_req),
    .ch        (ch_if.master),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int base  = 0;
  int fd_cnt = 0;
  logic [8:0] rxq [$];
  int         cmdq [$];
  logic [8:0] exp_b [9];

  // Scoreboard feed: every accepted byte, and the cycle of each frame's command byte.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ch_if.ch_valid && ch_if.ch_ready) begin
      rxq.push_back({ch_if.ch_is_cmd, ch_if.chcode});
      if (ch_if.ch_is_cmd) cmdq.push_back(cyc - base);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_outputs);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    if (check_outputs) begin
      check_eq("rst_chcode", {24'h0, ch_if.chcode}, 32'h00);
      check_eq("rst_is_cmd", {31'h0, ch_if.ch_is_cmd}, 32'h0);
      check_eq("rst_valid", {31'h0, ch_if.ch_valid}, 32'h0);
      check_eq("rst_busy", {31'h0, busy}, 32'h0);
      check_eq("rst_frame_done", {31'h0, frame_done}, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    base = cyc;
    rxq.delete();
    cmdq.delete();
    fd_cnt = 0;
  endtask

  task automatic wait_frame(input string tag, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      step();
      if (frame_done) seen = 1'b1;
    end
    check_eq({tag, "_done"}, {31'h0, seen}, 32'h1);
  endtask

  task automatic check_frame(input string tag);
    check_eq({tag, "_nbytes"}, rxq.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < rxq.size())
        check_eq($sformatf("%s_b%0d", tag, i), {23'h0, rxq[i]}, {23'h0, exp_b[i]});
      else
        check_eq($sformatf("%s_b%0d", tag, i), 32'hFFFF_FFFF, {23'h0, exp_b[i]});
    end
  endtask

  initial begin
    int fd_first;
    int fd_n;

    // Basic frame with reset values and exact timing.
    time_bcd = 24'h123456;
    ch_if.ch_ready = 1'b1;
    do_reset(1'b1);
    fd_first = -1;
    fd_n = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 1) begin
        check_eq("load_busy", {31'h0, busy}, 32'h1);
        check_eq("load_valid", {31'h0, ch_if.ch_valid}, 32'h0);
      end
      if (i == 20) check_eq("idle_busy", {31'h0, busy}, 32'h0);
      if (frame_done) begin
        fd_n++;
        if (fd_first < 0) fd_first = i;
      end
    end
    check_eq("fd_cycle", fd_first, 32'd19);
    check_eq("fd_pulses", fd_n, 32'd1);
    exp_b = '{9'h180, 9'h031, 9'h032, 9'h03A, 9'h033, 9'h034, 9'h03A, 9'h035, 9'h036};
    check_frame("basic");

    // Consumer stall on the first colon.
    time_bcd = 24'h123456;
    ch_if.ch_ready = 1'b1;
    do_reset(1'b0);
    repeat (8) step();
    ch_if.ch_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) step();
      check_eq($sformatf("stall_%0d", s),
               {22'h0, ch_if.ch_valid, ch_if.ch_is_cmd, ch_if.chcode}, 32'h23A);
    end
    ch_if.ch_ready = 1'b1;
    wait_frame("stall", 40);
    check_frame("stall");

    // Non-decimal nibbles.
    time_bcd = 24'hA95F00;
    do_reset(1'b0);
    wait_frame("badbcd", 40);
    exp_b = '{9'h180, 9'h03F, 9'h039, 9'h03A, 9'h035, 9'h03F, 9'h03A, 9'h030, 9'h030};
    check_frame("badbcd");

    // time_bcd changes mid-frame; the snapshot must be used.
    time_bcd = 24'h235959;
    do_reset(1'b0);
    repeat (5) step();
    time_bcd = 24'h000000;
    wait_frame("snap", 40);
    exp_b = '{9'h180, 9'h032, 9'h033, 9'h03A, 9'h035, 9'h039, 9'h03A, 9'h035, 9'h039};
    check_frame("snap");

    // Reset mid-frame at index 5, then a clean restart.
    time_bcd = 24'h123456;
    do_reset(1'b0);
    repeat (12) step();
    check_eq("pre_abort", {22'h0, ch_if.ch_valid, ch_if.ch_is_cmd, ch_if.chcode}, 32'h234);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_valid", {31'h0, ch_if.ch_valid}, 32'h0);
    check_eq("abort_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    base = cyc;
    rxq.delete();
    cmdq.delete();
    fd_cnt = 0;
    wait_frame("restart", 40);
    exp_b = '{9'h180, 9'h031, 9'h032, 9'h03A, 9'h033, 9'h034, 9'h03A, 9'h035, 9'h036};
    check_frame("restart");

    // Refresh period and collapsing of mid-frame update requests.
    time_bcd = 24'h123456;
    do_reset(1'b0);
    repeat (205) step();
    update_req = 1'b1;
    step();
    update_req = 1'b0;
    repeat (3) step();
    update_req = 1'b1;
    step();
    update_req = 1'b0;
    repeat (135) step();
    check_eq("n_frames", cmdq.size(), 32'd5);
    begin
      int exp_t [5];
      exp_t = '{3, 103, 203, 223, 323};
      for (int i = 0; i < 5; i++) begin
        if (i < cmdq.size())
          check_eq($sformatf("cmd_time_%0d", i), cmdq[i], exp_t[i]);
        else
          check_eq($sformatf("cmd_time_%0d", i), 32'hFFFF_FFFF, exp_t[i]);
      end
    end
    check_eq("fd_count", fd_cnt, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
